// File: rtl/pl_irq_catcher_if.sv
// Bus bundle between the PL interrupt catcher and its environment:
// trigger/ack/enable inputs plus the interrupt level and statistics readback.
interface pl_irq_catcher_if #(
   parameter int CNT_WID = 16
);
   logic               trig_in;
   logic               ack;
   logic               enable;
   logic               irq;
   logic               pending;
   logic [CNT_WID-1:0] event_count;
   logic [CNT_WID-1:0] missed_count;
   logic [CNT_WID-1:0] latency_count;

   modport master (
      output trig_in, ack, enable,
      input  irq, pending, event_count, missed_count, latency_count
   );

   modport slave (
      input  trig_in, ack, enable,
      output irq, pending, event_count, missed_count, latency_count
   );
endinterface

// File: rtl/pl_irq_catcher.sv
// Glitch-filtered timer trigger to PS level interrupt, held until a GPIO ack
// rising edge, with event / missed-event / service-latency statistics.
//
// state | meaning
// IDLE  | no interrupt outstanding, irq low
// PEND  | interrupt raised toward the PS, waiting for ack rising edge
module pl_irq_catcher #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 4,
   parameter int CNT_WID     = 16
) (
   input  logic            clk,
   input  logic            nrst,
   pl_irq_catcher_if.slave bus
);
   localparam int WC_W = $clog2(MIN_WIDTH + 1);

   typedef enum logic {IDLE, PEND} state_t;

   state_t               state, next_state;
   logic [SYNC_STAGES-1:0] trig_sync, ack_sync;
   logic                 trig_s, ack_s, ack_s_d;
   logic                 ack_rise, evt;
   logic [WC_W-1:0]      wcnt;
   logic [CNT_WID-1:0]   event_count, missed_count, latency_count, lat_run;
   logic                 ev_inc, miss_inc, lat_load, lat_clr;

   assign trig_s = trig_sync[SYNC_STAGES-1];
   assign ack_s  = ack_sync[SYNC_STAGES-1];

   // evt and ack_rise are both registered so that input-to-FSM latency is
   // identical for the trigger and acknowledge paths.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         trig_sync <= '0;
         ack_sync  <= '0;
         ack_s_d   <= 1'b0;
         ack_rise  <= 1'b0;
         wcnt      <= '0;
         evt       <= 1'b0;
      end else begin
         trig_sync <= {trig_sync[SYNC_STAGES-2:0], bus.trig_in};
         ack_sync  <= {ack_sync[SYNC_STAGES-2:0], bus.ack};
         ack_s_d   <= ack_s;
         ack_rise  <= ack_s & ~ack_s_d;
         if (!trig_s)
            wcnt <= '0;
         else if (wcnt != WC_W'(MIN_WIDTH))
            wcnt <= wcnt + WC_W'(1);
         evt <= trig_s && (wcnt == WC_W'(MIN_WIDTH - 1));
      end
   end

   always_comb begin
      next_state = state;
      ev_inc     = 1'b0;
      miss_inc   = 1'b0;
      lat_load   = 1'b0;
      lat_clr    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.enable && evt) begin
               next_state = PEND;
               ev_inc     = 1'b1;
               lat_clr    = 1'b1;
            end
         end
         PEND: begin
            if (!bus.enable) begin
               next_state = IDLE;
            end else if (evt && ack_rise) begin
               // back-to-back service: new event replaces the acked one, no irq gap
               lat_load = 1'b1;
               ev_inc   = 1'b1;
               lat_clr  = 1'b1;
            end else if (evt) begin
               miss_inc = 1'b1;
               ev_inc   = 1'b1;
            end else if (ack_rise) begin
               lat_load   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state         <= IDLE;
         event_count   <= '0;
         missed_count  <= '0;
         latency_count <= '0;
         lat_run       <= '0;
      end else begin
         state <= next_state;
         if (ev_inc)
            event_count <= event_count + CNT_WID'(1);
         if (miss_inc && (missed_count != '1))
            missed_count <= missed_count + CNT_WID'(1);
         if (lat_load)
            latency_count <= lat_run;
         if (lat_clr)
            lat_run <= '0;
         else if ((state == PEND) && (lat_run != '1))
            lat_run <= lat_run + CNT_WID'(1);
      end
   end

   assign bus.irq           = (state == PEND);
   assign bus.pending       = (state == PEND);
   assign bus.event_count   = event_count;
   assign bus.missed_count  = missed_count;
   assign bus.latency_count = latency_count;
endmodule

// File: tb/tb_pl_irq_catcher.sv
// Two catcher instances (default and narrow/fast configurations) driven by shared
// directed + random stimulus, checked every cycle against a history-based model.
module tb_pl_irq_catcher;
   localparam int S0 = 2, M0 = 4, W0 = 16;
   localparam int S1 = 3, M1 = 1, W1 = 4;
   localparam int MAXC = 8192;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic trig_in = 1'b0;
   logic ack = 1'b0;
   logic enable = 1'b0;

   always #5 clk = ~clk;

   pl_irq_catcher_if #(.CNT_WID(W0)) bus0();
   pl_irq_catcher_if #(.CNT_WID(W1)) bus1();

   assign bus0.trig_in = trig_in;
   assign bus0.ack     = ack;
   assign bus0.enable  = enable;
   assign bus1.trig_in = trig_in;
   assign bus1.ack     = ack;
   assign bus1.enable  = enable;

   pl_irq_catcher #(.SYNC_STAGES(S0), .MIN_WIDTH(M0), .CNT_WID(W0)) dut0 (
      .clk(clk), .nrst(nrst), .bus(bus0));
   pl_irq_catcher #(.SYNC_STAGES(S1), .MIN_WIDTH(M1), .CNT_WID(W1)) dut1 (
      .clk(clk), .nrst(nrst), .bus(bus1));

   int compared = 0;
   int mismatched = 0;

   // sampled input history, one entry per posedge
   bit ht [0:MAXC-1];
   bit ha [0:MAXC-1];
   int cyc = 0;
   bit valid = 1'b0;

   bit m_pend [2];
   int m_ec [2];
   int m_mc [2];
   int m_lc [2];
   int m_lat [2];

   function automatic int sp(int i); return (i == 0) ? S0 : S1; endfunction
   function automatic int mp(int i); return (i == 0) ? M0 : M1; endfunction
   function automatic int wp(int i); return (i == 0) ? W0 : W1; endfunction
   function automatic bit htr(int k); return (k < 0) ? 1'b0 : ht[k]; endfunction
   function automatic bit hak(int k); return (k < 0) ? 1'b0 : ha[k]; endfunction

   task automatic cmp(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // One model step: an event acts at edge n when exactly the M samples taken
   // S..S+M-1 edges earlier were high after a low; ack acts S+1 edges after its rise.
   task automatic model_step(input int i, input int n);
      int  s, m, maxv;
      bit  ev, ar;
      s = sp(i);
      m = mp(i);
      maxv = (1 << wp(i)) - 1;
      ev = 1'b1;
      for (int j = 1; j <= m; j++)
         if (!htr(n - s - j)) ev = 1'b0;
      if (htr(n - s - m - 1)) ev = 1'b0;
      ar = hak(n - s - 1) && !hak(n - s - 2);
      if (!enable) begin
         m_pend[i] = 1'b0;
      end else if (!m_pend[i]) begin
         if (ev) begin
            m_pend[i] = 1'b1;
            m_ec[i] = (m_ec[i] + 1) & maxv;
            m_lat[i] = 0;
         end
      end else begin
         if (ev && ar) begin
            m_lc[i] = m_lat[i];
            m_ec[i] = (m_ec[i] + 1) & maxv;
            m_lat[i] = 0;
         end else if (ev) begin
            if (m_mc[i] < maxv) m_mc[i] = m_mc[i] + 1;
            m_ec[i] = (m_ec[i] + 1) & maxv;
            if (m_lat[i] < maxv) m_lat[i] = m_lat[i] + 1;
         end else if (ar) begin
            m_lc[i] = m_lat[i];
            m_pend[i] = 1'b0;
         end else if (m_lat[i] < maxv) begin
            m_lat[i] = m_lat[i] + 1;
         end
      end
   endtask

   initial begin : model_and_compare
      forever begin
         @(posedge clk);
         if (cyc < MAXC) begin
            ht[cyc] = trig_in;
            ha[cyc] = ack;
         end
         if (!nrst) begin
            for (int j = 0; j <= 20; j++)
               if (cyc - j >= 0 && cyc - j < MAXC) begin
                  ht[cyc-j] = 1'b0;
                  ha[cyc-j] = 1'b0;
               end
            for (int i = 0; i < 2; i++) begin
               m_pend[i] = 1'b0;
               m_ec[i] = 0;
               m_mc[i] = 0;
               m_lc[i] = 0;
               m_lat[i] = 0;
            end
            valid = 1'b1;
         end else begin
            for (int i = 0; i < 2; i++) model_step(i, cyc);
         end
         cyc++;
         #1;
         if (valid) begin
            cmp("irq0", int'(bus0.irq), int'(m_pend[0]));
            cmp("pending0", int'(bus0.pending), int'(m_pend[0]));
            cmp("event_count0", int'(bus0.event_count), m_ec[0]);
            cmp("missed_count0", int'(bus0.missed_count), m_mc[0]);
            cmp("latency_count0", int'(bus0.latency_count), m_lc[0]);
            cmp("irq1", int'(bus1.irq), int'(m_pend[1]));
            cmp("pending1", int'(bus1.pending), int'(m_pend[1]));
            cmp("event_count1", int'(bus1.event_count), m_ec[1]);
            cmp("missed_count1", int'(bus1.missed_count), m_mc[1]);
            cmp("latency_count1", int'(bus1.latency_count), m_lc[1]);
         end
      end
   end

   task automatic cyc_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin : stimulus
      int trun, arun;
      cyc_n(3);
      nrst = 1'b1;
      enable = 1'b1;
      cyc_n(3);

      // 9-cycle pulse, then ack 20 cycles after irq rises
      trig_in = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (k == 6) cmp("t1_irq_early", int'(bus0.irq), 0);
         if (k == 7) begin
            cmp("t1_irq_rise", int'(bus0.irq), 1);
            cmp("t1_event", int'(bus0.event_count), 1);
            cmp("t1_missed", int'(bus0.missed_count), 0);
            cmp("t1_model_pend", int'(m_pend[0]), 1);
         end
         if (k == 9) trig_in = 1'b0;
         if (k == 26) ack = 1'b1;
         if (k == 29) cmp("lat_irq_hold", int'(bus0.irq), 1);
         if (k == 30) begin
            cmp("lat_irq_fall", int'(bus0.irq), 0);
            cmp("lat_pending", int'(bus0.pending), 0);
            cmp("lat_value", int'(bus0.latency_count), 22);
            cmp("lat_model", m_lc[0], 22);
            ack = 1'b0;
         end
      end

      // too-short pulse, then minimum-width pulse
      cyc_n(5);
      trig_in = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 3) trig_in = 1'b0;
      end
      cmp("short_irq", int'(bus0.irq), 0);
      cmp("short_event", int'(bus0.event_count), 1);
      trig_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 4) trig_in = 1'b0;
         if (k == 6) cmp("minw_irq_early", int'(bus0.irq), 0);
         if (k == 7) begin
            cmp("minw_irq", int'(bus0.irq), 1);
            cmp("minw_event", int'(bus0.event_count), 2);
         end
      end

      // second event while pending counts as missed
      cyc_n(4);
      trig_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 5) trig_in = 1'b0;
      end
      cmp("miss_missed", int'(bus0.missed_count), 1);
      cmp("miss_event", int'(bus0.event_count), 3);
      cmp("miss_irq", int'(bus0.irq), 1);

      // ack rise and event on the same cycle
      cyc_n(4);
      trig_in = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 3) ack = 1'b1;
         if (k == 6) trig_in = 1'b0;
         if (k == 10) ack = 1'b0;
         cmp("same_irq_held", int'(bus0.irq), 1);
      end
      cmp("same_event", int'(bus0.event_count), 4);
      cmp("same_missed", int'(bus0.missed_count), 1);

      // disable while pending, trigger while disabled, re-enable mid-pulse
      cyc_n(2);
      enable = 1'b0;
      @(negedge clk);
      cmp("dis_irq", int'(bus0.irq), 0);
      trig_in = 1'b1;
      cyc_n(6);
      trig_in = 1'b0;
      cyc_n(10);
      cmp("dis_event", int'(bus0.event_count), 4);
      cmp("dis_missed", int'(bus0.missed_count), 1);
      trig_in = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 8) enable = 1'b1;
         if (k == 12) trig_in = 1'b0;
      end
      cmp("reen_irq", int'(bus0.irq), 0);
      cmp("reen_event", int'(bus0.event_count), 4);

      // reset while pending, then event with ack held high
      cyc_n(3);
      trig_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 5) trig_in = 1'b0;
      end
      cmp("prerst_irq", int'(bus0.irq), 1);
      cmp("prerst_event", int'(bus0.event_count), 5);
      ack = 1'b1;
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      cmp("rst_irq", int'(bus0.irq), 0);
      cmp("rst_pending", int'(bus0.pending), 0);
      cmp("rst_event", int'(bus0.event_count), 0);
      cmp("rst_missed", int'(bus0.missed_count), 0);
      cmp("rst_latency", int'(bus0.latency_count), 0);
      cyc_n(8);
      trig_in = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 9) trig_in = 1'b0;
         if (k == 7) begin
            cmp("ackhi_irq", int'(bus0.irq), 1);
            cmp("ackhi_event", int'(bus0.event_count), 1);
         end
      end
      cmp("ackhi_irq_held", int'(bus0.irq), 1);
      ack = 1'b0;
      cyc_n(3);
      ack = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 3) cmp("toggle_irq_hold", int'(bus0.irq), 1);
         if (k == 4) cmp("toggle_irq_fall", int'(bus0.irq), 0);
      end
      ack = 1'b0;
      cyc_n(4);

      // randomized traffic
      trun = 0;
      arun = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (trun == 0) begin
            trig_in = ~trig_in;
            trun = trig_in ? $urandom_range(1, 8) : $urandom_range(1, 12);
         end
         trun--;
         if (arun == 0) begin
            ack = ~ack;
            arun = $urandom_range(1, 40);
         end
         arun--;
         if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
         nrst = ($urandom_range(0, 999) != 0);
      end
      nrst = 1'b1;
      cyc_n(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pl_irq_catcher.md
Name: pl_irq_catcher

Overview:
PL-side interrupt capture block. It receives a periodic trigger pulse from a PL timer (trig_in) and glitch-filters it. It converts each qualified pulse into a level interrupt (irq) toward the PS and holds irq until the PS acknowledges via a GPIO line (ack). It also keeps event, missed-event and service-latency statistics for software readback.

Parameters:
SYNC_STAGES, 2, flip-flop synchroniser depth applied to trig_in and ack; legal values 2..4.
MIN_WIDTH, 4, consecutive synchronised-high cycles required to accept a trigger; legal values >= 1.
CNT_WID, 16, width of the statistics counters.

Ports:
clk  in  1  system clock
nrst  in  1  synchronous, active-low reset
trig_in  in  1  trigger pulse from the timer; asynchronous to clk is allowed
ack  in  1  PS acknowledge, level from GPIO; only its rising edge is used
enable  in  1  1 = capture events; 0 = block idle
irq  out  1  level interrupt to PS (IRQ_F2P)
pending  out  1  state is PEND; equals irq
event_count  out  CNT_WID  accepted events; wraps
missed_count  out  CNT_WID  events accepted while already pending; saturates
latency_count  out  CNT_WID  irq-assert to ack cycles for the last serviced event; saturates

Behaviour:
- Reset (nrst=0 at a posedge):
  - All sync registers, width counter and stat counters go to 0.
  - State goes to IDLE; irq=0, pending=0.
  - Reset mid-PEND drops irq on that same edge.
- Synchronisers:
  - trig_in and ack each pass through SYNC_STAGES flops, giving trig_s and ack_s.
  - ack_rise = ack_s & ~ack_s_d (one extra flop).
- Trigger qualifier:
  - wcnt counts consecutive cycles of trig_s=1 and saturates at MIN_WIDTH.
  - wcnt clears to 0 on trig_s=0.
  - evt is a 1-cycle strobe asserted when wcnt transitions MIN_WIDTH-1 -> MIN_WIDTH. This gives exactly one evt per high run.
  - Runs shorter than MIN_WIDTH produce no evt.
- Latency requirements:
  - irq rises on the posedge SYNC_STAGES+MIN_WIDTH cycles after the first posedge that samples trig_in=1.
  - irq falls on the posedge SYNC_STAGES+1 cycles after the first posedge that samples ack=1.
- FSM:
  - State IDLE:
    - evt & enable -> PEND.
    - event_count+1; lat_run cleared to 0.
    - ack_rise ignored.
  - State PEND (irq=1):
    - lat_run increments each cycle, saturating at all-ones.
    - evt without ack_rise -> missed_count+1 (saturating) and event_count+1; stay in PEND.
    - ack_rise without evt -> latency_count <= lat_run, go to IDLE, irq=0 next cycle.
    - ack_rise and evt in the same cycle -> latency_count <= lat_run, event_count+1, lat_run <= 0, stay in PEND. irq remains 1 with no gap. Not counted as missed.
- enable=0:
  - evt ignored; no counter changes.
  - PEND is forced to IDLE on the next posedge; irq=0; latency_count unchanged.
  - Sync and qualifier logic keep running, so re-enabling in the middle of a high run does not create a false evt.
- Counter width rules:
  - event_count wraps from all-ones to 0.
  - missed_count and latency_count saturate at all-ones.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Reset then enable=1, 9-cycle trig_in pulse (defaults) -> irq=1 exactly 6 cycles after the first high sample; event_count=1; missed_count=0.
- 3-cycle trig_in pulse, MIN_WIDTH=4 -> irq stays 0; event_count stays 0. Then a 4-cycle pulse -> irq=1, event_count=1.
- While irq=1, hold for 20 cycles then pulse ack -> irq=0 three cycles after ack sampled high; latency_count = cycles irq was high before ack_rise (check = 20 + sync delay per the formula); pending=0.
- Two qualified triggers with no ack -> missed_count=1, event_count=2, irq held. Then ack with evt in the same cycle -> irq never drops, missed_count unchanged, event_count=3.
- enable dropped while PEND -> irq=0 the next cycle. A trigger during enable=0 -> counters unchanged. Re-enable mid-pulse -> no event.
- Assert nrst=0 for 1 cycle while PEND with nonzero counters -> irq, pending and all counters read 0 after that edge. Then a 9-cycle pulse with ack held high -> event accepted; no ack_rise until ack toggles.
